// File: rtl/exec_alu_stage.sv
// exec_alu_stage
//   Execute stage fed by the operand-2 shifter. It checks the ARM condition
//   field against the internal NZCV register and performs one of the sixteen
//   data-processing operations. The result, destination and write enable are
//   registered toward writeback behind a valid/ready handshake. This stage
//   owns the architectural NZCV flags.
//
// Ports
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready = !out_valid || out_ready)
//   cond, opcode       condition field and data-processing opcode
//   s_bit              set-flags request
//   rn_val, src2       first operand and shifted second operand
//   shift_carry        shifter carry-out, used as C by the logical ops
//   rd_addr            destination register
//   out_valid/out_ready downstream handshake toward writeback
//   result, out_rd     registered ALU result and destination
//   wr_en              writeback must write result to out_rd
//   flags_nzcv         current flag register {N,Z,C,V}
module exec_alu_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cond,
    input  logic [3:0]        opcode,
    input  logic              s_bit,
    input  logic [DATA_W-1:0] rn_val,
    input  logic [DATA_W-1:0] src2,
    input  logic              shift_carry,
    input  logic [REG_AW-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [REG_AW-1:0] out_rd,
    output logic              wr_en,
    output logic [3:0]        flags_nzcv
);

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    logic              flag_n, flag_z, flag_c, flag_v;
    logic              accept;
    logic              cond_pass;
    logic              is_test;
    logic              is_arith;
    logic [DATA_W-1:0] op_x, op_y;
    logic              carry_in;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        new_flags;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_nzcv;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_test  = (opcode[3:2] == 2'b10);

    // Condition evaluation against the flags currently held in the register.
    // Flags written by the previous accept are already visible here because
    // they land on the same edge as that accept.
    always_comb begin
        cond_pass = 1'b0;
        unique case (cond)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // All arithmetic ops share one adder: the operands are swapped and/or
    // inverted up front so that subtract variants become x + ~y + cin.
    // Carry out of the adder is therefore "no borrow" for subtracts, and the
    // overflow test looks at the already-inverted second operand.
    always_comb begin
        is_arith = 1'b1;
        op_x     = rn_val;
        op_y     = src2;
        carry_in = 1'b0;
        alu_res  = '0;
        unique case (opcode)
            OP_SUB, OP_CMP: begin op_y = ~src2; carry_in = 1'b1; end
            OP_RSB:         begin op_x = src2; op_y = ~rn_val; carry_in = 1'b1; end
            OP_ADD, OP_CMN: carry_in = 1'b0;
            OP_ADC:         carry_in = flag_c;
            OP_SBC:         begin op_y = ~src2; carry_in = flag_c; end
            OP_RSC:         begin op_x = src2; op_y = ~rn_val; carry_in = flag_c; end
            default:        is_arith = 1'b0;
        endcase

        sum = {1'b0, op_x} + {1'b0, op_y} + {{DATA_W{1'b0}}, carry_in};

        unique case (opcode)
            OP_AND, OP_TST: alu_res = rn_val & src2;
            OP_EOR, OP_TEQ: alu_res = rn_val ^ src2;
            OP_ORR:         alu_res = rn_val | src2;
            OP_MOV:         alu_res = src2;
            OP_BIC:         alu_res = rn_val & ~src2;
            OP_MVN:         alu_res = ~src2;
            default:        alu_res = sum[DATA_W-1:0];
        endcase

        new_flags[3] = alu_res[DATA_W-1];
        new_flags[2] = (alu_res == '0);
        if (is_arith) begin
            new_flags[1] = sum[DATA_W];
            new_flags[0] = (op_x[DATA_W-1] == op_y[DATA_W-1]) &&
                           (sum[DATA_W-1] != op_x[DATA_W-1]);
        end else begin
            new_flags[1] = shift_carry;
            new_flags[0] = flag_v;
        end
    end

    // Output register and flag register. An accept always produces an output
    // beat, even when the condition fails, so writeback sees every
    // instruction in order; a failed condition simply carries wr_en=0 and a
    // zero result and leaves the flags alone. When nothing new arrives and
    // the current beat is consumed, only out_valid drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            result     <= '0;
            out_rd     <= '0;
            wr_en      <= 1'b0;
            flags_nzcv <= 4'b0000;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_rd    <= rd_addr;
            if (cond_pass) begin
                result <= alu_res;
                wr_en  <= !is_test;
                if (s_bit || is_test) begin
                    flags_nzcv <= new_flags;
                end
            end else begin
                result <= '0;
                wr_en  <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_alu_stage.sv
// tb_exec_alu_stage
//   Directed-vector bench for exec_alu_stage. Every expected value below was
//   worked out by hand from the ARM data-processing rules.
module tb_exec_alu_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [31:0] rn_val;
    logic [31:0] src2;
    logic        shift_carry;
    logic [3:0]  rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  out_rd;
    logic        wr_en;
    logic [3:0]  flags_nzcv;

    int vector_count = 0;
    int fail_count   = 0;

    // Opcode sweep with A=0000F0F0, B=00FF00FF, s_bit=0 and flag C=0.
    logic [3:0]  tbl_op  [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                  4'h6, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [31:0] tbl_exp [12] = '{32'h000000F0, 32'h00FFF00F, 32'hFF01EFF1,
                                  32'h00FE100F, 32'h00FFF1EF, 32'h00FFF1EF,
                                  32'hFF01EFF0, 32'h00FE100E, 32'h00FFF0FF,
                                  32'h00FF00FF, 32'h0000F000, 32'hFF00FF00};

    exec_alu_stage #(.DATA_W(32), .REG_AW(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cond        (cond),
        .opcode      (opcode),
        .s_bit       (s_bit),
        .rn_val      (rn_val),
        .src2        (src2),
        .shift_carry (shift_carry),
        .rd_addr     (rd_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .out_rd      (out_rd),
        .wr_en       (wr_en),
        .flags_nzcv  (flags_nzcv)
    );

    // Free-running 100 MHz clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every vector and reports miscompares.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        vector_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one instruction onto the input buses on the falling edge.
    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] op,
                                 input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input logic sc,
                                 input logic [3:0] rd);
        @(negedge clock);
        in_valid    = 1'b1;
        cond        = c;
        opcode      = op;
        s_bit       = s;
        rn_val      = a;
        src2        = b;
        shift_carry = sc;
        rd_addr     = rd;
    endtask

    // Advances past the next rising edge and settles before sampling.
    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Directed sequence: flag-setting arithmetic, conditional execution,
    // asynchronous reset, backpressure, and an opcode sweep.
    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cond = 4'h0; opcode = 4'h0; s_bit = 1'b0; rn_val = '0; src2 = '0;
        shift_carry = 1'b0; rd_addr = '0;
        stepCycle();
        stepCycle();
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_flags",     {28'b0, flags_nzcv}, 32'h0);
        checkOutput("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        checkOutput("rst_result",    result, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;

        applyStimulus(4'hE, 4'h4, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4'd3);
        stepCycle();
        checkOutput("adds_result", result, 32'h0);
        checkOutput("adds_wr_en",  {31'b0, wr_en}, 32'd1);
        checkOutput("adds_flags",  {28'b0, flags_nzcv}, 32'h6);
        checkOutput("adds_rd",     {28'b0, out_rd}, 32'd3);

        applyStimulus(4'hE, 4'hA, 1'b0, 32'd5, 32'd5, 1'b0, 4'd1);
        stepCycle();
        checkOutput("cmp_wr_en", {31'b0, wr_en}, 32'd0);
        checkOutput("cmp_flags", {28'b0, flags_nzcv}, 32'h6);

        applyStimulus(4'h0, 4'hD, 1'b0, 32'h0, 32'h00001234, 1'b0, 4'd2);
        stepCycle();
        checkOutput("moveq_result", result, 32'h00001234);
        checkOutput("moveq_wr_en",  {31'b0, wr_en}, 32'd1);

        applyStimulus(4'h1, 4'hD, 1'b0, 32'h0, 32'h00001234, 1'b0, 4'd2);
        stepCycle();
        checkOutput("movne_wr_en",  {31'b0, wr_en}, 32'd0);
        checkOutput("movne_result", result, 32'h0);
        checkOutput("movne_valid",  {31'b0, out_valid}, 32'd1);
        checkOutput("movne_flags",  {28'b0, flags_nzcv}, 32'h6);

        applyStimulus(4'hE, 4'h2, 1'b1, 32'h80000000, 32'h00000001, 1'b0, 4'd4);
        stepCycle();
        checkOutput("subs_result", result, 32'h7FFFFFFF);
        checkOutput("subs_flags",  {28'b0, flags_nzcv}, 32'h3);

        applyStimulus(4'hE, 4'h5, 1'b1, 32'h7FFFFFFF, 32'h0, 1'b0, 4'd5);
        stepCycle();
        checkOutput("adcs_result", result, 32'h80000000);
        checkOutput("adcs_flags",  {28'b0, flags_nzcv}, 32'h9);

        applyStimulus(4'hE, 4'h0, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 4'd6);
        stepCycle();
        checkOutput("ands_result", result, 32'h0);
        checkOutput("ands_flags",  {28'b0, flags_nzcv}, 32'h7);

        applyStimulus(4'hE, 4'hA, 1'b0, 32'd5, 32'd5, 1'b0, 4'd7);
        stepCycle();
        checkOutput("cmp2_flags", {28'b0, flags_nzcv}, 32'h6);
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stepCycle();
        checkOutput("hold_valid",    {31'b0, out_valid}, 32'd1);
        checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("arst_flags",     {28'b0, flags_nzcv}, 32'h0);
        checkOutput("arst_in_ready",  {31'b0, in_ready}, 32'd1);
        checkOutput("arst_wr_en",     {31'b0, wr_en}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        applyStimulus(4'hE, 4'h4, 1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 4'd8);
        stepCycle();
        checkOutput("bp1_result", result, 32'h80000000);
        checkOutput("bp1_flags",  {28'b0, flags_nzcv}, 32'h9);
        applyStimulus(4'h6, 4'h2, 1'b1, 32'd3, 32'd5, 1'b0, 4'd9);
        #1;
        checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
        stepCycle();
        checkOutput("bp_hold_result", result, 32'h80000000);
        checkOutput("bp_hold_rd",     {28'b0, out_rd}, 32'd8);
        checkOutput("bp_hold_flags",  {28'b0, flags_nzcv}, 32'h9);
        @(negedge clock);
        out_ready = 1'b1;
        stepCycle();
        checkOutput("bp2_result", result, 32'hFFFFFFFE);
        checkOutput("bp2_rd",     {28'b0, out_rd}, 32'd9);
        checkOutput("bp2_flags",  {28'b0, flags_nzcv}, 32'h8);
        checkOutput("bp2_valid",  {31'b0, out_valid}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        stepCycle();
        checkOutput("drain_valid", {31'b0, out_valid}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'hE, tbl_op[i], 1'b0, 32'h0000F0F0, 32'h00FF00FF,
                          1'b0, 4'(i));
            stepCycle();
            checkOutput($sformatf("op%0h_result", tbl_op[i]), result, tbl_exp[i]);
            checkOutput($sformatf("op%0h_rd", tbl_op[i]), {28'b0, out_rd}, i);
        end
        checkOutput("sweep_flags", {28'b0, flags_nzcv}, 32'h8);

        applyStimulus(4'hB, 4'hD, 1'b0, 32'h0, 32'h00000001, 1'b0, 4'd1);
        stepCycle();
        checkOutput("movlt_wr_en", {31'b0, wr_en}, 32'd1);
        applyStimulus(4'hA, 4'hD, 1'b0, 32'h0, 32'h00000001, 1'b0, 4'd1);
        stepCycle();
        checkOutput("movge_wr_en", {31'b0, wr_en}, 32'd0);
        applyStimulus(4'hF, 4'h4, 1'b1, 32'h1, 32'h1, 1'b0, 4'd1);
        stepCycle();
        checkOutput("nv_wr_en",  {31'b0, wr_en}, 32'd0);
        checkOutput("nv_flags",  {28'b0, flags_nzcv}, 32'h8);
        applyStimulus(4'hE, 4'h9, 1'b0, 32'h12345678, 32'h12345678, 1'b0, 4'd1);
        stepCycle();
        checkOutput("teq_wr_en", {31'b0, wr_en}, 32'd0);
        checkOutput("teq_flags", {28'b0, flags_nzcv}, 32'h4);
        @(negedge clock);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, fail_count);
        $finish;
    end

endmodule
